prbs_link_test_ctrl: RTL
========================

PRBS_LINK_TEST_CTRL -- requirements
Module: prbs_link_test_ctrl

Interface
REQ-001 SHALL expose parameter LOCK_CNT, default 16: consecutive clean valid words in SYNC required to declare lock (range 1..255).
REQ-002 SHALL expose parameter UNLOCK_ERRS, default 4: consecutive errored valid words in LOCKED that drop lock (range 1..15).
REQ-003 SHALL expose parameter TEST_LEN, default 0: valid words checked in LOCKED before DONE; 0 = run until stop.
REQ-004 SHALL have ports: clk in 1 (single clock); rst in 1 (asynchronous, active-high reset).
REQ-005 SHALL have ports: start in 1 (begin test pulse); stop in 1 (abort pulse); rx_valid in 1 (rx_data qualifier); rx_data in 32 (received word, bit 0 earliest in time).
REQ-006 SHALL have ports: gen_en out 1 (enables local PRBS-7 generator); inject_mask out 32 (XOR mask applied to TX word by datapath); inject_err in 1 (error-injection request pulse).
REQ-007 SHALL have ports: state out 2 (IDLE=0, SYNC=1, LOCKED=2, DONE=3); busy out 1; locked out 1; done out 1 (one-cycle pulse); lock_lost out 1 (sticky); err_cnt out 32; word_cnt out 32.

Function
REQ-008 SHALL check PRBS-7 self-synchronously: window w[63:0] = {rx_data, prev_word}; bit error e[k] = w[k] ^ w[k-7] ^ w[k-6] for k = 32..63 (b[n+7] = b[n]^b[n+1]).
REQ-009 SHALL update prev_word only on rx_valid; cycles without rx_valid SHALL change no counter or state except via start/stop.
REQ-010 SHALL treat the first valid word after entering SYNC as priming only: no error evaluation, no counter updates.
REQ-011 SHALL classify a valid word as errored if any e[k]=1 or rx_data == 32'h0 (all-zero lockup guard).
REQ-012 IDLE: gen_en=0; start -> SYNC, clearing err_cnt, word_cnt, lock_lost and internal run counters.
REQ-013 SYNC: gen_en=1; clean word increments clean-run counter, errored word clears it; reaching LOCK_CNT -> LOCKED next cycle.
REQ-014 LOCKED: gen_en=1, locked=1; each valid word increments word_cnt and adds popcount(e[63:32]) to err_cnt, saturating at 32'hFFFFFFFF.
REQ-015 LOCKED: UNLOCK_ERRS consecutive errored words -> SYNC, set lock_lost, re-prime per REQ-010; err_cnt and word_cnt retained.
REQ-016 LOCKED: word_cnt reaching nonzero TEST_LEN -> DONE with done=1 for exactly one cycle; gen_en=0 in DONE.
REQ-017 DONE: counters and lock_lost hold; start -> SYNC per REQ-012.
REQ-018 stop in any state -> IDLE next cycle; counters and lock_lost hold; stop and start in same cycle: stop wins.
REQ-019 start while in SYNC or LOCKED SHALL be ignored.
REQ-020 busy = (state == SYNC or LOCKED); all outputs registered, latency one cycle from rx_valid word to counter update.

Reset
REQ-021 rst asserted SHALL asynchronously force state=IDLE, gen_en=0, locked=0, done=0, lock_lost=0, err_cnt=0, word_cnt=0, inject_mask=0, prev_word=0, run counters=0.
REQ-022 rst mid-test SHALL abandon the run; no done pulse generated on deassertion.

Configuration
REQ-023 With PRBS_ERR_INJECT_EN defined: inject_err while state==LOCKED SHALL drive inject_mask=32'h00000001 for exactly one cycle; requests in other states are dropped.
REQ-024 Without PRBS_ERR_INJECT_EN: inject_mask SHALL be constant 0 and inject_err ignored.

Verification
REQ-025 Assert rst mid-LOCKED -> all outputs zero, state=0 within same cycle, no done after release.
REQ-026 start, clean PRBS-7 stream, rx_valid every cycle, LOCK_CNT=16 -> locked=1 after 1 priming + 16 words (+1 cycle), err_cnt=0.
REQ-027 Locked, flip one bit in one word (away from word end) -> err_cnt increments by exactly 3 total, lock held (UNLOCK_ERRS=4).
REQ-028 start with rx_data=32'h0 continuously for 200 cycles -> state stays SYNC, locked=0.
REQ-029 Locked, 4 consecutive garbage words -> state=SYNC, lock_lost=1; clean stream resumes -> relock after 1+16 words.
REQ-030 TEST_LEN=100, clean stream -> word_cnt=100, one-cycle done, state=DONE; with PRBS_ERR_INJECT_EN and loopback, one inject_err -> err_cnt=3.

Source files
------------

// File: rtl/prbs_link_test_ctrl.sv
// prbs_link_test_ctrl: PRBS-7 link test controller.
// Self-synchronous checker over 32-bit received words, lock/unlock tracking,
// error and word counters, optional single-bit error injection.
// Optional feature macro: PRBS_ERR_INJECT_EN (enables inject_mask pulse on inject_err).
module prbs_link_test_ctrl #(
   parameter int unsigned LOCK_CNT    = 16,
   parameter int unsigned UNLOCK_ERRS = 4,
   parameter int unsigned TEST_LEN    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        rx_valid,
   input  logic [31:0] rx_data,
   output logic        gen_en,
   output logic [31:0] inject_mask,
   input  logic        inject_err,
   output logic [1:0]  state,
   output logic        busy,
   output logic        locked,
   output logic        done,
   output logic        lock_lost,
   output logic [31:0] err_cnt,
   output logic [31:0] word_cnt
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned TAIL_W  = 7;
   localparam int unsigned CLEAN_W = 8;
   localparam int unsigned BAD_W   = 4;
   localparam int unsigned POP_W   = 6;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SYNC   = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Only the last 7 bits of the previous word feed the PRBS-7 checks.
   logic [TAIL_W-1:0]  prev_tail;
   logic               prime;
   logic [CLEAN_W-1:0] clean_run;
   logic [BAD_W-1:0]   bad_run;

   logic [1:0]         state_n;
   logic               prime_n;
   logic [CLEAN_W-1:0] clean_n;
   logic [BAD_W-1:0]   bad_n;
   logic [WORD_W-1:0]  err_n;
   logic [WORD_W-1:0]  word_n;
   logic               lost_n;

   logic [WORD_W+TAIL_W-1:0] seq;
   logic [WORD_W-1:0]        err_vec;
   logic [POP_W-1:0]         err_pop;
   logic                     word_bad;
   logic [WORD_W:0]          err_sum;

   // Per-bit PRBS-7 check (b[n] = b[n-7] ^ b[n-6]), popcount and saturating sum.
   always_comb begin
      seq     = {rx_data, prev_tail};
      err_vec = '0;
      err_pop = '0;
      for (int k = 0; k < 32; k++) begin
         err_vec[k] = seq[k+7] ^ seq[k] ^ seq[k+1];
      end
      for (int i = 0; i < 32; i++) begin
         err_pop = err_pop + POP_W'(err_vec[i]);
      end
      word_bad = (|err_vec) || (rx_data == 32'h0);
      err_sum  = {1'b0, err_cnt} + (WORD_W+1)'(err_pop);
   end

   // Next-state and next counter values.
   always_comb begin
      state_n = state;
      prime_n = prime;
      clean_n = clean_run;
      bad_n   = bad_run;
      err_n   = err_cnt;
      word_n  = word_cnt;
      lost_n  = lock_lost;
      if (stop) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_n = S_SYNC;
                  prime_n = 1'b1;
                  clean_n = '0;
                  bad_n   = '0;
                  err_n   = '0;
                  word_n  = '0;
                  lost_n  = 1'b0;
               end
            end
            S_SYNC: begin
               if (rx_valid) begin
                  if (prime) begin
                     prime_n = 1'b0;
                  end else if (word_bad) begin
                     clean_n = '0;
                  end else if (clean_run == CLEAN_W'(LOCK_CNT - 1)) begin
                     state_n = S_LOCKED;
                     clean_n = '0;
                     bad_n   = '0;
                  end else begin
                     clean_n = clean_run + CLEAN_W'(1);
                  end
               end
            end
            S_LOCKED: begin
               if (rx_valid) begin
                  word_n = word_cnt + WORD_W'(1);
                  err_n  = err_sum[WORD_W] ? '1 : err_sum[WORD_W-1:0];
                  bad_n  = word_bad ? bad_run + BAD_W'(1) : '0;
                  if ((TEST_LEN != 0) && (word_n == WORD_W'(TEST_LEN))) begin
                     state_n = S_DONE;
                  end else if (word_bad && (bad_run == BAD_W'(UNLOCK_ERRS - 1))) begin
                     state_n = S_SYNC;
                     lost_n  = 1'b1;
                     prime_n = 1'b1;
                     clean_n = '0;
                     bad_n   = '0;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         prime     <= 1'b0;
         clean_run <= '0;
         bad_run   <= '0;
         err_cnt   <= '0;
         word_cnt  <= '0;
         lock_lost <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         gen_en    <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_n;
         prime     <= prime_n;
         clean_run <= clean_n;
         bad_run   <= bad_n;
         err_cnt   <= err_n;
         word_cnt  <= word_n;
         lock_lost <= lost_n;
         done      <= (state == S_LOCKED) && (state_n == S_DONE);
         busy      <= (state_n == S_SYNC) || (state_n == S_LOCKED);
         gen_en    <= (state_n == S_SYNC) || (state_n == S_LOCKED);
         locked    <= (state_n == S_LOCKED);
      end
   end

   // Previous-word history, advanced on every valid word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_tail <= '0;
      end else if (rx_valid) begin
         prev_tail <= rx_data[WORD_W-1:WORD_W-TAIL_W];
      end
   end

`ifdef PRBS_ERR_INJECT_EN
   // One-cycle single-bit TX error pulse, honoured only while locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inject_mask <= '0;
      end else begin
         inject_mask <= ((state == S_LOCKED) && inject_err) ? 32'h0000_0001 : 32'h0;
      end
   end
`else
   logic unused_inject_err;
   assign unused_inject_err = inject_err;

   // Injection disabled: mask held at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inject_mask <= '0;
      end else begin
         inject_mask <= '0;
      end
   end
`endif

endmodule
